// File: rtl/load_seq_if.sv
// rtl/load_seq_if.sv - load sequencer bus bundle (control, memory port, write-back)
// Optional macro LOAD_SEQ_SIGNED_EN adds the sign-extension request line.
// master: the environment (control unit plus memory port) driving requests and read data.
// slave : the load sequencer itself.
interface load_seq_if;
  logic        start;
  logic [1:0]  command;
  logic [31:0] addr;
`ifdef LOAD_SEQ_SIGNED_EN
  logic        sign;
`endif
  logic [31:0] mem_data;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic [31:0] data_out;
  logic        done;
  logic        err;
  logic        busy;

  modport master (
    output start,
    output command,
    output addr,
`ifdef LOAD_SEQ_SIGNED_EN
    output sign,
`endif
    output mem_data,
    input  mem_rd,
    input  mem_addr,
    input  data_out,
    input  done,
    input  err,
    input  busy
  );

  modport slave (
    input  start,
    input  command,
    input  addr,
`ifdef LOAD_SEQ_SIGNED_EN
    input  sign,
`endif
    input  mem_data,
    output mem_rd,
    output mem_addr,
    output data_out,
    output done,
    output err,
    output busy
  );
endinterface

// File: rtl/load_seq.sv
// rtl/load_seq.sv - multi-cycle load sequencer with byte/halfword/word lane extraction
// Optional macro LOAD_SEQ_SIGNED_EN: enables the sign line and LB/LH sign extension;
// without it every byte/halfword load is zero-extended.
module load_seq #(
  parameter int MEM_LATENCY = 1
) (
  input  logic   i_clk,
  input  logic   i_reset,
  load_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_WAIT = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  // The counter counts the remaining WAIT cycles; zero marks the data-capture edge.
  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic [1:0]  r_off;
  logic [1:0]  r_cmd;
  logic        r_sign;
  logic [29:0] r_mem_addr;
  logic [31:0] r_data_out;

  logic        w_misaligned;
  logic        w_accept;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_fill_b;
  logic        w_fill_h;
  logic [31:0] w_ext;

  // Halfwords need addr[0]=0, words need addr[1:0]=0; bytes are always aligned.
  always_comb begin
    w_misaligned = 1'b0;
    case (bus.command)
      2'b00:   w_misaligned = 1'b0;
      2'b01:   w_misaligned = bus.addr[0];
      default: w_misaligned = (bus.addr[1:0] != 2'b00);
    endcase
    w_accept = (r_state == S_IDLE) && bus.start && !w_misaligned;
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; start is only looked at in IDLE so it is never queued.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_next = w_misaligned ? S_ERR : S_READ;
        end
      end
      S_READ:  w_next = S_WAIT;
      S_WAIT:  w_next = (r_cnt == 4'd0) ? S_DONE : S_WAIT;
      S_DONE:  w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Little-endian lane select from the returned word, then fill the upper bits.
  always_comb begin
    w_byte = bus.mem_data[7:0];
    case (r_off)
      2'd0: w_byte = bus.mem_data[7:0];
      2'd1: w_byte = bus.mem_data[15:8];
      2'd2: w_byte = bus.mem_data[23:16];
      2'd3: w_byte = bus.mem_data[31:24];
      default: w_byte = bus.mem_data[7:0];
    endcase
    w_half = r_off[1] ? bus.mem_data[31:16] : bus.mem_data[15:0];
`ifdef LOAD_SEQ_SIGNED_EN
    w_fill_b = r_sign & w_byte[7];
    w_fill_h = r_sign & w_half[15];
`else
    w_fill_b = 1'b0;
    w_fill_h = 1'b0;
`endif
    case (r_cmd)
      2'b00:   w_ext = {{24{w_fill_b}}, w_byte};
      2'b01:   w_ext = {{16{w_fill_h}}, w_half};
      default: w_ext = bus.mem_data;
    endcase
  end

  // Request latch, wait counter and result register; a reset mid-load clears the result.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt      <= 4'd0;
      r_off      <= 2'd0;
      r_cmd      <= 2'd0;
      r_sign     <= 1'b0;
      r_mem_addr <= 30'd0;
      r_data_out <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_off      <= bus.addr[1:0];
            r_cmd      <= bus.command;
`ifdef LOAD_SEQ_SIGNED_EN
            r_sign     <= bus.sign;
`else
            r_sign     <= 1'b0;
`endif
            r_mem_addr <= bus.addr[31:2];
          end
        end
        S_READ: begin
          r_cnt <= CNT_INIT;
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_data_out <= w_ext;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Status outputs are decoded straight from the state so done and err can never overlap.
  assign bus.mem_rd   = (r_state == S_READ);
  assign bus.done     = (r_state == S_DONE);
  assign bus.err      = (r_state == S_ERR);
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.mem_addr = {r_mem_addr, 2'b00};
  assign bus.data_out = r_data_out;

  // r_sign is only consumed by the signed build.
  logic w_unused;
  assign w_unused = r_sign;

endmodule

// File: tb/tb_load_seq.sv
// tb/tb_load_seq.sv - self-checking bench for load_seq (latency 1 and latency 3 instances)
module tb_load_seq;

`ifdef LOAD_SEQ_SIGNED_EN
  localparam bit SIGNED_BUILD = 1'b1;
`else
  localparam bit SIGNED_BUILD = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        start_s;
  logic        sel;
  logic [1:0]  cmd_s;
  logic [31:0] addr_s;
  logic        sign_s;
  logic [31:0] md;

  int n_checks;
  int n_errs;

  logic [31:0] m_data  [2];
  logic [31:0] m_maddr [2];

  load_seq_if u_if1 ();
  load_seq_if u_if3 ();

  assign u_if1.start    = start_s & ~sel;
  assign u_if1.command  = cmd_s;
  assign u_if1.addr     = addr_s;
  assign u_if1.mem_data = md;
  assign u_if3.start    = start_s & sel;
  assign u_if3.command  = cmd_s;
  assign u_if3.addr     = addr_s;
  assign u_if3.mem_data = md;
`ifdef LOAD_SEQ_SIGNED_EN
  assign u_if1.sign     = sign_s;
  assign u_if3.sign     = sign_s;
`endif

  load_seq #(.MEM_LATENCY(1)) u_dut1 (.i_clk(clk), .i_reset(reset), .bus(u_if1));
  load_seq #(.MEM_LATENCY(3)) u_dut3 (.i_clk(clk), .i_reset(reset), .bus(u_if3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic o_rd(input logic s);
    return s ? u_if3.mem_rd : u_if1.mem_rd;
  endfunction
  function automatic logic o_done(input logic s);
    return s ? u_if3.done : u_if1.done;
  endfunction
  function automatic logic o_err(input logic s);
    return s ? u_if3.err : u_if1.err;
  endfunction
  function automatic logic o_busy(input logic s);
    return s ? u_if3.busy : u_if1.busy;
  endfunction
  function automatic logic [31:0] o_data(input logic s);
    return s ? u_if3.data_out : u_if1.data_out;
  endfunction
  function automatic logic [31:0] o_maddr(input logic s);
    return s ? u_if3.mem_addr : u_if1.mem_addr;
  endfunction

  // Reference: load size in bytes decides alignment; lanes are picked by shifting.
  function automatic bit model_mis(input logic [1:0] c, input logic [31:0] a);
    int unsigned nbytes;
    nbytes = (c == 2'd0) ? 1 : ((c == 2'd1) ? 2 : 4);
    return (a % nbytes) != 0;
  endfunction

  function automatic logic [31:0] model_val(input logic [1:0] c, input logic [31:0] a,
                                            input logic [31:0] w, input bit sg);
    int unsigned width;
    int unsigned shift;
    logic [31:0] mask;
    logic [31:0] v;
    if (c >= 2'd2) return w;
    width = (c == 2'd0) ? 8 : 16;
    shift = (c == 2'd0) ? 8 * (a % 4) : 16 * ((a % 4) / 2);
    mask  = (32'd1 << width) - 32'd1;
    v     = (w >> shift) & mask;
    if (sg && (((v >> (width - 1)) & 32'd1) == 32'd1)) v = v | ~mask;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One complete load starting in cycle 0 from IDLE; returns in the first cycle after done/err.
  task automatic do_load(input logic s, input logic [1:0] c, input logic [31:0] a,
                         input logic sg, input logic [31:0] w, input logic extra);
    int lat;
    int rd_cnt;
    bit mis;
    logic [31:0] ev;
    lat = s ? 3 : 1;
    mis = model_mis(c, a);
    ev  = model_val(c, a, w, sg & SIGNED_BUILD);
    sel = s; cmd_s = c; addr_s = a; sign_s = sg; start_s = 1'b1; md = $urandom;
    chk1("c0_busy", o_busy(s), 1'b0);
    tick;
    start_s = extra;
    md = $urandom;
    rd_cnt = int'(o_rd(s));
    if (mis) begin
      chk1("mis_err", o_err(s), 1'b1);
      chk1("mis_rd", o_rd(s), 1'b0);
      chk1("mis_done", o_done(s), 1'b0);
      chk1("mis_busy", o_busy(s), 1'b1);
      chk("mis_maddr", o_maddr(s), m_maddr[s]);
      chk("mis_data", o_data(s), m_data[s]);
      tick;
      start_s = 1'b0;
      chk1("mis_c2_busy", o_busy(s), 1'b0);
      chk1("mis_c2_err", o_err(s), 1'b0);
      chk1("mis_c2_done", o_done(s), 1'b0);
      chk1("mis_c2_rd", o_rd(s), 1'b0);
      chk("mis_c2_data", o_data(s), m_data[s]);
    end else begin
      chk1("c1_rd", o_rd(s), 1'b1);
      chk("c1_maddr", o_maddr(s), {a[31:2], 2'b00});
      chk1("c1_busy", o_busy(s), 1'b1);
      chk1("c1_err", o_err(s), 1'b0);
      m_maddr[s] = {a[31:2], 2'b00};
      tick;
      start_s = 1'b0;
      for (int cy = 2; cy <= 1 + lat; cy++) begin
        rd_cnt += int'(o_rd(s));
        chk1("wait_done", o_done(s), 1'b0);
        chk1("wait_busy", o_busy(s), 1'b1);
        md = (cy == 1 + lat) ? w : $urandom;
        tick;
      end
      md = $urandom;
      rd_cnt += int'(o_rd(s));
      chk1("done_pulse", o_done(s), 1'b1);
      chk1("done_err", o_err(s), 1'b0);
      chk1("done_busy", o_busy(s), 1'b1);
      chk("done_data", o_data(s), ev);
      m_data[s] = ev;
      tick;
      rd_cnt += int'(o_rd(s));
      chk1("post_done", o_done(s), 1'b0);
      chk1("post_busy", o_busy(s), 1'b0);
      chk("post_data", o_data(s), ev);
      chk("rd_count", 32'(rd_cnt), 32'd1);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errs   = 0;
    m_data[0] = 32'd0; m_data[1] = 32'd0;
    m_maddr[0] = 32'd0; m_maddr[1] = 32'd0;
    reset = 1'b1; start_s = 1'b1; sel = 1'b0; cmd_s = 2'd2; addr_s = 32'h100;
    sign_s = 1'b0; md = 32'h0;

    // Reset held two cycles with start high: both instances stay quiet.
    for (int k = 0; k < 2; k++) begin
      tick;
      for (int d = 0; d < 2; d++) begin
        chk1("rst_rd", o_rd(d[0]), 1'b0);
        chk1("rst_done", o_done(d[0]), 1'b0);
        chk1("rst_err", o_err(d[0]), 1'b0);
        chk1("rst_busy", o_busy(d[0]), 1'b0);
        chk("rst_data", o_data(d[0]), 32'd0);
        chk("rst_maddr", o_maddr(d[0]), 32'd0);
      end
    end
    reset = 1'b0;

    // Directed loads; each returns in the cycle a back-to-back start is allowed.
    do_load(1'b0, 2'd2, 32'h0000_0100, 1'b0, 32'hDEAD_BEEF, 1'b0);
    do_load(1'b0, 2'd0, 32'h0000_0103, 1'b0, 32'h80AB_CD12, 1'b0);
    do_load(1'b0, 2'd0, 32'h0000_0103, 1'b1, 32'h80AB_CD12, 1'b0);
    do_load(1'b0, 2'd0, 32'h0000_0100, 1'b1, 32'h80AB_CD12, 1'b0);
    do_load(1'b0, 2'd1, 32'h0000_0102, 1'b0, 32'h8001_1234, 1'b0);
    do_load(1'b0, 2'd1, 32'h0000_0102, 1'b1, 32'h8001_1234, 1'b0);
    do_load(1'b1, 2'd1, 32'h0000_0102, 1'b1, 32'h8001_1234, 1'b0);
    do_load(1'b0, 2'd1, 32'h0000_0101, 1'b0, 32'h1111_2222, 1'b0);
    do_load(1'b0, 2'd3, 32'h0000_0102, 1'b0, 32'h3333_4444, 1'b0);
    do_load(1'b0, 2'd3, 32'h0000_0204, 1'b0, 32'h0BAD_F00D, 1'b0);
    do_load(1'b1, 2'd2, 32'h0000_0300, 1'b0, 32'h1234_5678, 1'b1);

    // Reset during WAIT on the latency-3 instance aborts the load.
    sel = 1'b1; cmd_s = 2'd2; addr_s = 32'h0000_0400; start_s = 1'b1; md = $urandom;
    tick;
    start_s = 1'b0;
    tick;
    tick;
    chk1("abort_in_wait", o_busy(1'b1), 1'b1);
    reset = 1'b1;
    tick;
    chk1("abort_busy", o_busy(1'b1), 1'b0);
    chk1("abort_done", o_done(1'b1), 1'b0);
    chk1("abort_rd", o_rd(1'b1), 1'b0);
    chk("abort_data", o_data(1'b1), 32'd0);
    chk("abort_maddr", o_maddr(1'b1), 32'd0);
    chk("abort_data_l1", o_data(1'b0), 32'd0);
    reset = 1'b0;
    m_data[0] = 32'd0; m_data[1] = 32'd0;
    m_maddr[0] = 32'd0; m_maddr[1] = 32'd0;
    for (int k = 0; k < 4; k++) begin
      tick;
      chk1("abort_no_done", o_done(1'b1), 1'b0);
      chk1("abort_no_err", o_err(1'b1), 1'b0);
      chk1("abort_no_rd", o_rd(1'b1), 1'b0);
    end

    // Randomized loads across both latencies, all sizes and alignments.
    for (int n = 0; n < 60; n++) begin
      do_load(1'($urandom), 2'($urandom), $urandom, 1'($urandom), $urandom,
              1'($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
